icache_fifo_reader: RTL and testbench

Drain-side controller for the 8-slot instruction FIFO behind the Icache. It mirrors the FIFO's write pointer with an occupancy counter, because the FIFO exports no empty flag. It pops entries into a 2-entry output buffer that feeds decode over a valid/ready handshake, and it holds back entries still marked as waiting for refill. It is also the sole driver of the FIFO's state-write and clean ports, forwarding refill-unit updates and pipeline flushes.

---
 rtl/icache_fifo_reader_if.sv | 49 ++++
 rtl/icache_fifo_reader.sv | 104 ++++++++++
 tb/tb_icache_fifo_reader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fifo_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fifo_reader_if
//  Purpose  : Bundles the FIFO drain, refill-update and decode-side handshake
//             signals of the Icache instruction FIFO reader.
//  Revision : 1.0  initial release
// ============================================================================
interface icache_fifo_reader_if #(
  parameter int FIFOWIDE = 38
);
  // FIFO side
  logic                WrPush;
  logic [FIFOWIDE-1:0] FifoPreOut;
  logic [2:0]          FifoPrePtr;
  logic                Rable;
  logic                StateWAble;
  logic [2:0]          StatePtr;
  logic [2:0]          StateDate;
  logic                FifoClean;
  // refill unit and pipeline control
  logic                RefillWAble;
  logic [2:0]          RefillPtr;
  logic [2:0]          RefillState;
  logic                FlushReq;
  // decode side
  logic                OutValid;
  logic [FIFOWIDE-1:0] OutData;
  logic                OutReady;
  // status
  logic [2:0]          Occupancy;
  logic                ErrOvf;

  // Environment view: drives the FIFO, refill and decode inputs.
  modport master (
    output WrPush, FifoPreOut, FifoPrePtr, RefillWAble, RefillPtr,
           RefillState, FlushReq, OutReady,
    input  Rable, StateWAble, StatePtr, StateDate, FifoClean,
           OutValid, OutData, Occupancy, ErrOvf
  );

  // Reader view.
  modport slave (
    input  WrPush, FifoPreOut, FifoPrePtr, RefillWAble, RefillPtr,
           RefillState, FlushReq, OutReady,
    output Rable, StateWAble, StatePtr, StateDate, FifoClean,
           OutValid, OutData, Occupancy, ErrOvf
  );
endinterface
`default_nettype wire

// File: rtl/icache_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fifo_reader
//  Purpose  : Drain-side controller for the 8-slot Icache instruction FIFO.
//             Tracks occupancy from the write enable, pops ready entries into
//             a 2-entry output buffer for decode, holds back WAIT entries and
//             forwards refill state updates and flushes to the FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fifo_reader #(
  parameter int FIFOWIDE = 38
) (
  input wire logic            Clk,
  input wire logic            Rest,
  icache_fifo_reader_if.slave bus
);

  localparam logic [2:0] c_ST_WAIT  = 3'b001;
  localparam logic [3:0] c_OCC_MAX  = 4'd7;

  logic [2:0]          r_occ;
  logic                r_err;
  logic [1:0]          r_cnt;
  logic [FIFOWIDE-1:0] r_head;
  logic [FIFOWIDE-1:0] r_tail;

  logic                w_head_ok;
  logic                w_pop;
  logic                w_accept;
  logic [3:0]          w_occ_sum;
  logic                w_unused_ok;

  // The read pointer is not needed: occupancy alone decides emptiness.
  assign w_unused_ok = ^bus.FifoPrePtr;

  // Head may leave the FIFO when present and not waiting for refill. The
  // buffer-room term uses only the registered count so Rable never depends
  // on OutReady in the same cycle.
  assign w_head_ok = (r_occ != 3'd0) && (bus.FifoPreOut[4:2] != c_ST_WAIT);
  assign w_pop     = w_head_ok && (r_cnt < 2'd2) && !bus.FlushReq;
  assign w_accept  = (r_cnt != 2'd0) && bus.OutReady;

  // Widened so a push at 7 with no pop is visible as 8 and can saturate.
  assign w_occ_sum = {1'b0, r_occ} + {3'b000, bus.WrPush} - {3'b000, w_pop};

  assign bus.Rable      = w_pop;
  assign bus.FifoClean  = bus.FlushReq && Rest;
  assign bus.StateWAble = bus.RefillWAble && !bus.FlushReq && Rest;
  assign bus.StatePtr   = bus.RefillPtr;
  assign bus.StateDate  = bus.RefillState;
  assign bus.OutValid   = (r_cnt != 2'd0);
  assign bus.OutData    = r_head;
  assign bus.Occupancy  = r_occ;
  assign bus.ErrOvf     = r_err;

  // Occupancy mirror of the FIFO write/read pointers, plus sticky overflow.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_occ <= 3'd0;
      r_err <= 1'b0;
    end else if (bus.FlushReq) begin
      r_occ <= 3'd0;
    end else begin
      r_occ <= (w_occ_sum > c_OCC_MAX) ? 3'd7 : w_occ_sum[2:0];
      if (bus.WrPush && (r_occ == 3'd7)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Two-slot output buffer; head is always the oldest entry.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else if (bus.FlushReq) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_pop, w_accept})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head <= bus.FifoPreOut;
          end else begin
            r_tail <= bus.FifoPreOut;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Pop only happens below two entries, so one entry is buffered here.
          r_head <= bus.FifoPreOut;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fifo_reader
//  Purpose  : Self-checking bench for icache_fifo_reader with a behavioural
//             8-slot FIFO and an id scoreboard on the decode side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_fifo_reader;
  localparam int FIFOWIDE = 38;

  logic Clk  = 1'b0;
  logic Rest = 1'b0;
  always #5 Clk = ~Clk;

  icache_fifo_reader_if #(.FIFOWIDE(FIFOWIDE)) bus ();
  icache_fifo_reader #(.FIFOWIDE(FIFOWIDE)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Behavioural FIFO and scoreboard state
  logic [FIFOWIDE-1:0] m_mem [8];
  logic [2:0]          m_wp;
  logic [2:0]          m_rp;
  int                  m_level;
  int                  m_buf;
  logic [32:0]         wr_id;
  logic [2:0]          wr_st;
  logic [32:0]         sb_q [$];
  logic [32:0]         exp_id;
  int                  n_acc = 0;
  bit                  mon_en = 1'b0;

  assign bus.FifoPreOut = m_mem[m_rp];
  assign bus.FifoPrePtr = m_rp;

  // FIFO model: push/pop/state-write/clean, expected ids queued on push.
  always @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      m_wp    <= 3'd0;
      m_rp    <= 3'd0;
      m_level <= 0;
      m_buf   <= 0;
      for (int i = 0; i < 8; i++) m_mem[i] <= '0;
      sb_q.delete();
    end else if (bus.FlushReq) begin
      m_wp    <= 3'd0;
      m_rp    <= 3'd0;
      m_level <= 0;
      m_buf   <= 0;
      sb_q.delete();
    end else begin
      if (bus.StateWAble) m_mem[bus.StatePtr][4:2] <= bus.StateDate;
      if (bus.WrPush) begin
        m_mem[m_wp] <= {wr_id, wr_st, 2'b00};
        m_wp        <= m_wp + 3'd1;
        sb_q.push_back(wr_id);
      end
      if (bus.Rable) m_rp <= m_rp + 3'd1;
      m_level <= m_level + int'(bus.WrPush) - int'(bus.Rable);
      m_buf   <= m_buf + int'(bus.Rable) - int'(bus.OutValid && bus.OutReady);
    end
  end

  // Decode-side monitor: order/loss/duplication and stream invariants.
  always @(negedge Clk) begin
    if (Rest && bus.OutValid && bus.OutReady) begin
      if (sb_q.size() != 0) exp_id = sb_q.pop_front();
      else exp_id = '1;
      check("sb_data", bus.OutData[37:5], exp_id);
      n_acc++;
    end
    if (mon_en) begin
      check("occ_track", bus.Occupancy, m_level[2:0]);
      check("valid_track", bus.OutValid, m_buf != 0);
      if (m_buf == 2) check("rable_full", bus.Rable, 1'b0);
    end
  end

  int  base;
  int  pushed;
  bit  done;

  initial begin
    bus.WrPush      = 1'b0;
    bus.RefillWAble = 1'b1;
    bus.RefillPtr   = 3'd5;
    bus.RefillState = 3'd3;
    bus.FlushReq    = 1'b1;
    bus.OutReady    = 1'b0;
    wr_id           = '0;
    wr_st           = 3'b000;
    Rest            = 1'b0;
    tick();
    tick();
    // Reset values, with refill and flush requests held active
    check("rst_occ",   bus.Occupancy, 0);
    check("rst_valid", bus.OutValid, 0);
    check("rst_data",  bus.OutData, 0);
    check("rst_err",   bus.ErrOvf, 0);
    check("rst_rable", bus.Rable, 0);
    check("rst_swe",   bus.StateWAble, 0);
    check("rst_clean", bus.FifoClean, 0);
    bus.RefillWAble = 1'b0;
    bus.FlushReq    = 1'b0;
    Rest            = 1'b1;
    tick();

    // Three pushes flowing straight through
    bus.OutReady = 1'b1;
    bus.WrPush   = 1'b1;
    wr_id        = 33'd1;
    tick();
    check("t1_occ_n1",   bus.Occupancy, 1);
    check("t1_rable_n1", bus.Rable, 1);
    check("t1_valid_n1", bus.OutValid, 0);
    wr_id = 33'd2;
    tick();
    check("t1_valid_n2", bus.OutValid, 1);
    check("t1_data_n2",  bus.OutData[37:5], 1);
    check("t1_occ_n2",   bus.Occupancy, 1);
    wr_id = 33'd3;
    tick();
    check("t1_occ_n3", bus.Occupancy, 1);
    bus.WrPush = 1'b0;
    tick();
    check("t1_occ_n4", bus.Occupancy, 0);
    repeat (3) tick();
    check("t1_valid_end", bus.OutValid, 0);
    check("t1_acc", n_acc, 3);

    // Fill with decode stalled, then overflow
    bus.OutReady = 1'b0;
    bus.WrPush   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_id = 33'(10 + i);
      tick();
    end
    bus.WrPush = 1'b0;
    tick();
    check("t2_occ5",  bus.Occupancy, 5);
    check("t2_valid", bus.OutValid, 1);
    check("t2_rable", bus.Rable, 0);
    check("t2_head",  bus.OutData[37:5], 10);
    bus.WrPush = 1'b1;
    wr_id      = 33'd17;
    tick();
    wr_id = 33'd18;
    tick();
    check("t2_occ7",   bus.Occupancy, 7);
    check("t2_err0",   bus.ErrOvf, 0);
    wr_id = 33'd19;
    tick();
    bus.WrPush = 1'b0;
    check("t2_err1",   bus.ErrOvf, 1);
    check("t2_occsat", bus.Occupancy, 7);
    Rest = 1'b0;
    tick();
    check("t2_err_rst", bus.ErrOvf, 0);
    Rest = 1'b1;
    tick();

    // WAIT head at slot 2 with a ready entry queued behind it
    base         = n_acc;
    bus.OutReady = 1'b1;
    bus.WrPush   = 1'b1;
    wr_id = 33'd20; wr_st = 3'b000; tick();
    wr_id = 33'd21; wr_st = 3'b000; tick();
    wr_id = 33'd22; wr_st = 3'b001; tick();
    wr_id = 33'd23; wr_st = 3'b000; tick();
    bus.WrPush = 1'b0;
    wr_st      = 3'b000;
    check("t3_ptr",     bus.FifoPrePtr, 2);
    check("t3_rable_a", bus.Rable, 0);
    tick();
    check("t3_occ2",    bus.Occupancy, 2);
    check("t3_rable_b", bus.Rable, 0);
    bus.RefillWAble = 1'b1;
    bus.RefillPtr   = 3'd2;
    bus.RefillState = 3'b000;
    #1;
    check("t3_swe",    bus.StateWAble, 1);
    check("t3_sptr",   bus.StatePtr, 2);
    check("t3_sdata",  bus.StateDate, 0);
    check("t3_rable_c", bus.Rable, 0);
    tick();
    bus.RefillWAble = 1'b0;
    check("t3_release", bus.Rable, 1);
    repeat (5) tick();
    check("t3_occ0", bus.Occupancy, 0);
    check("t3_acc",  n_acc - base, 4);

    // Flush with queued entries, coincident push and refill write
    bus.OutReady = 1'b0;
    bus.WrPush   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_id = 33'(30 + i);
      tick();
    end
    bus.WrPush = 1'b0;
    tick();
    check("t4_occ4", bus.Occupancy, 4);
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady    = 1'b0;
    bus.FlushReq    = 1'b1;
    bus.WrPush      = 1'b1;
    wr_id           = 33'd36;
    bus.RefillWAble = 1'b1;
    bus.RefillPtr   = 3'd3;
    #1;
    check("t4_clean", bus.FifoClean, 1);
    check("t4_swe",   bus.StateWAble, 0);
    check("t4_rable", bus.Rable, 0);
    tick();
    bus.FlushReq    = 1'b0;
    bus.WrPush      = 1'b0;
    bus.RefillWAble = 1'b0;
    check("t4_occ0",   bus.Occupancy, 0);
    check("t4_valid0", bus.OutValid, 0);
    tick();
    check("t4_occ_stay", bus.Occupancy, 0);

    // Random-ready stream of 20 entries across the pointer wrap
    base   = n_acc;
    pushed = 0;
    done   = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      bus.OutReady = 1'($urandom_range(0, 1));
      if (pushed < 20 && m_level < 7 && $urandom_range(0, 3) != 0) begin
        bus.WrPush = 1'b1;
        wr_id      = 33'(100 + pushed);
        pushed++;
      end else begin
        bus.WrPush = 1'b0;
      end
      tick();
      done = (pushed == 20) && (sb_q.size() == 0) && !bus.WrPush;
    end
    bus.WrPush   = 1'b0;
    bus.OutReady = 1'b0;
    mon_en       = 1'b0;
    check("t5_drain", sb_q.size(), 0);
    check("t5_acc",   n_acc - base, 20);

    // Asynchronous reset in the middle of a cycle
    bus.WrPush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_id = 33'(200 + i);
      tick();
    end
    bus.WrPush = 1'b0;
    tick();
    check("t6_pre_valid", bus.OutValid, 1);
    check("t6_pre_occ",   bus.Occupancy, 2);
    #2;
    Rest = 1'b0;
    #1;
    check("t6_occ",   bus.Occupancy, 0);
    check("t6_valid", bus.OutValid, 0);
    check("t6_data",  bus.OutData, 0);
    check("t6_err",   bus.ErrOvf, 0);
    check("t6_rable", bus.Rable, 0);
    tick();
    Rest = 1'b1;
    tick();
    check("t6_post_occ", bus.Occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
